// File: rtl/v_multiword_adder_ctrl_pkg.sv
// v_multiword_adder_ctrl_pkg: shared state encoding and sizing helper for the word-serial adder
//   state_t   : ST_IDLE=1'b0, ST_RUN=1'b1
//   cnt_width : word counter width, max(1, ceil(log2(n)))
package v_multiword_adder_ctrl_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/v_add_cico.sv
// v_add_cico: combinational WIDTH-bit adder with carry-in and carry-out
//   a, b : operand words      ci  : carry in
//   sum  : result word        co  : carry out
module v_add_cico #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
endmodule

// File: rtl/v_multiword_adder_ctrl.sv
// v_multiword_adder_ctrl: word-serial NWORDS*WIDTH-bit adder controller, LS word first
//   C, CLR              : clock, async active-high reset
//   START, CI           : begin operation (IDLE only), initial carry
//   IN_VALID/IN_READY   : A/B word pair handshake
//   OUT_VALID/OUT_READY : SUM word handshake, with LAST and final CO
//   BUSY, DONE          : operation in progress, pulse after final word leaves
module v_multiword_adder_ctrl
  import v_multiword_adder_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             START,
  input  logic             CI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             LAST,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = cnt_width(NWORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);
  state_t          st;
  logic            carry_reg;
  logic [CW-1:0]   cnt;
  logic            in_done;
  logic [WIDTH-1:0] s;
  logic            c;
  logic            accept;
  logic            last_w;
  v_add_cico #(.WIDTH(WIDTH)) u_add (
    .a  (A),
    .b  (B),
    .ci (carry_reg),
    .sum(s),
    .co (c)
  );
  // A new word may enter only when the output slot is empty or draining this cycle
  assign IN_READY = (st == ST_RUN) & ~in_done & (~OUT_VALID | OUT_READY);
  assign accept   = IN_VALID & IN_READY;
  assign last_w   = cnt == LAST_IDX;
  assign BUSY     = st == ST_RUN;
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      st        <= ST_IDLE;
      carry_reg <= 1'b0;
      cnt       <= '0;
      in_done   <= 1'b0;
      OUT_VALID <= 1'b0;
      SUM       <= '0;
      LAST      <= 1'b0;
      CO        <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (st == ST_IDLE) begin
        if (START) begin
          st        <= ST_RUN;
          carry_reg <= CI;
          cnt       <= '0;
          in_done   <= 1'b0;
        end
      end else if (accept) begin
        SUM       <= s;
        carry_reg <= c;
        OUT_VALID <= 1'b1;
        LAST      <= last_w;
        CO        <= last_w & c;
        // Hold at the last index so the counter never wraps within an operation
        cnt       <= last_w ? cnt : cnt + CW'(1);
        in_done   <= in_done | last_w;
      end else if (OUT_VALID & OUT_READY) begin
        OUT_VALID <= 1'b0;
        if (LAST) begin
          st   <= ST_IDLE;
          DONE <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_v_multiword_adder_ctrl.sv
// tb_v_multiword_adder_ctrl: table-driven and directed checks of the word-serial adder controller
module tb_v_multiword_adder_ctrl;
  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic       START = 1'b0;
  logic       CI = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] SUM;
  logic       LAST;
  logic       CO;
  logic       BUSY;
  logic       DONE;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic        ci;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        co;
  } vec_t;
  vec_t vt[7];
  v_multiword_adder_ctrl #(.WIDTH(8), .NWORDS(4)) dut (
    .C(C), .CLR(CLR), .START(START), .CI(CI),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .B(B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM),
    .LAST(LAST), .CO(CO), .BUSY(BUSY), .DONE(DONE)
  );
  always #5 C = ~C;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic chk_idle_zero(input string name);
    chk(name, {IN_READY, OUT_VALID, SUM, LAST, CO, BUSY, DONE}, 32'h0);
  endtask
  task automatic tick();
    @(posedge C);
    @(negedge C);
  endtask
  task automatic run_op(input string name, input logic ci, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_sum, input logic exp_co,
                        input int in_gap, input int out_gap, input int stall, input logic start_mid);
    int in_i = 0;
    int out_i = 0;
    int stall_left = stall;
    START = 1'b1;
    CI = ci;
    tick();
    START = 1'b0;
    chk({name, "_busy"}, {31'b0, BUSY}, 32'h1);
    for (int cyc = 0; cyc < 400 && out_i < 4; cyc++) begin
      START = start_mid;
      CI = ~ci;
      IN_VALID = (in_i < 4) && ($urandom_range(99) >= in_gap);
      A = 8'(a >> (8 * (in_i & 3)));
      B = 8'(b >> (8 * (in_i & 3)));
      OUT_READY = $urandom_range(99) >= out_gap;
      if (stall_left > 0 && out_i == 0 && OUT_VALID) OUT_READY = 1'b0;
      #1;
      if (stall_left > 0 && out_i == 0 && OUT_VALID) begin
        chk({name, "_stall_in_ready"}, {31'b0, IN_READY}, 32'h0);
        chk({name, "_stall_sum"}, {24'b0, SUM}, {24'b0, exp_sum[7:0]});
        stall_left--;
      end
      if (IN_VALID && IN_READY) in_i++;
      if (OUT_VALID && OUT_READY) begin
        chk({name, "_sum_word"}, {24'b0, SUM}, 32'(8'(exp_sum >> (8 * out_i))));
        chk({name, "_last_co"}, {30'b0, LAST, CO}, (out_i == 3) ? {30'b0, 1'b1, exp_co} : 32'h0);
        out_i++;
      end
      tick();
    end
    START = 1'b0;
    IN_VALID = 1'b0;
    if (out_i < 4) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout words=%0d exp=4", name, out_i);
    end
    chk({name, "_done"}, {29'b0, DONE, BUSY, OUT_VALID}, 32'h4);
    tick();
    chk({name, "_done_pulse"}, {31'b0, DONE}, 32'h0);
  endtask
  initial begin
    vt[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vt[1] = '{1'b1, 32'h78563412, 32'h00000000, 32'h78563413, 1'b0};
    vt[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    vt[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vt[4] = '{1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0};
    vt[5] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vt[6] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0};
    tick();
    tick();
    chk_idle_zero("reset_async");
    CLR = 1'b0;
    tick();
    chk_idle_zero("reset_released");
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vt[i].ci, vt[i].a, vt[i].b, vt[i].sum, vt[i].co, 0, 0, 0, 1'b0);
    run_op("stall", 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 0, 0, 3, 1'b0);
    START = 1'b1;
    CI = 1'b1;
    tick();
    START = 1'b0;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    A = 8'h12;
    B = 8'h00;
    tick();
    A = 8'h34;
    tick();
    CLR = 1'b1;
    IN_VALID = 1'b0;
    #1;
    chk_idle_zero("clr_mid_async");
    tick();
    CLR = 1'b0;
    tick();
    chk_idle_zero("clr_mid_after");
    run_op("after_clr", 1'b1, 32'h78563412, 32'h00000000, 32'h78563413, 1'b0, 0, 0, 0, 1'b0);
    IN_VALID = 1'b1;
    A = 8'hAA;
    B = 8'h55;
    OUT_READY = 1'b1;
    #1;
    chk("idle_in_ready", {31'b0, IN_READY}, 32'h0);
    tick();
    tick();
    chk("idle_no_output", {30'b0, OUT_VALID, BUSY}, 32'h0);
    IN_VALID = 1'b0;
    run_op("start_mid", 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 0, 0, 0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [32:0] ref_sum;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      run_op("rand", rc, ra, rb, ref_sum[31:0], ref_sum[32], 30, 30, 0, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
